// File: rtl/led_scan_pkg.sv
// Shared types, geometry constants and frame-buffer word indexing for the LED matrix scanner.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FETCH = 2'd2,
    SHOW  = 2'd3
  } state_e;

  localparam int unsigned ROWS            = 16;
  localparam int unsigned COLS            = 32;
  localparam int unsigned BLOCKS          = 4;
  localparam int unsigned WORDS_PER_FRAME = 16;

  // Word = frame*16 + block*4 + row%4; the byte lane (row/4) is picked separately.
  function automatic logic [7:0] word_index(input logic [3:0] frame,
                                            input logic [3:0] row,
                                            input logic [1:0] block);
    return {frame, block, row[1:0]};
  endfunction

endpackage

// File: rtl/led_scan_addr_gen.sv
// Combinational frame-buffer byte address and read-data byte-lane select for one block fetch.
module led_scan_addr_gen
  import led_scan_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic [3:0]  frame_i,
  input  logic [3:0]  row_i,
  input  logic [1:0]  block_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] addr_o,
  output logic [7:0]  lane_o
);

  logic [7:0] word_s;

  // Byte address of the word feeding this block, wrapping modulo 2^32.
  always_comb begin
    word_s = word_index(frame_i, row_i, block_i);
    addr_o = BASE_ADDR + {22'd0, word_s, 2'b00};
  end

  // Rows 0-3 use lane 0, rows 4-7 lane 1, and so on.
  always_comb begin
    case (row_i[3:2])
      2'd0:    lane_o = rd_data_i[7:0];
      2'd1:    lane_o = rd_data_i[15:8];
      2'd2:    lane_o = rd_data_i[23:16];
      2'd3:    lane_o = rd_data_i[31:24];
      default: lane_o = 8'hFF;
    endcase
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-at-a-time scanner for a 16x32 active-low LED matrix fed from the shared dmem frame buffer.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that gates the row drive.
module led_matrix_scanner
  import led_scan_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned DWELL_CYCLES = 5000,
  parameter int unsigned FRAME_REPEAT = 30,
  parameter int unsigned NUM_FRAMES   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  output logic        mem_cs,
  input  logic [31:0] mem_rd,
  output logic [15:0] row_n,
  output logic [31:0] col_n,
  output logic [3:0]  frame_idx,
  output logic        frame_start
`ifdef LED_SCAN_BRIGHTNESS_EN
  ,
  input  logic [3:0]  brightness
`endif
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [15:0] SCAN_LAST  = 16'(FRAME_REPEAT - 1);
  localparam logic [3:0]  FRAME_LAST = 4'(NUM_FRAMES - 1);
  localparam logic [3:0]  ROW_LAST   = 4'(ROWS - 1);

  state_e      state_q, state_d;
  logic [1:0]  block_q, block_d;
  logic [3:0]  row_q, row_d;
  logic [15:0] scan_q, scan_d;
  logic [3:0]  frame_q, frame_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] col_q, col_d;
  logic [15:0] row_n_q, row_n_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        frame_start_q, frame_start_d;
  logic [3:0]  last_frame_q, last_frame_d;
  logic        shown_q, shown_d;

  logic [31:0] addr_s;
  logic [7:0]  lane_s;
  logic        capture_s;
  logic        enter_show_s;
  logic        dwell_term_s;
  logic        lit_s;

  led_scan_addr_gen #(
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .frame_i   (frame_q),
    .row_i     (row_q),
    .block_i   (block_q),
    .rd_data_i (mem_rd),
    .addr_o    (addr_s),
    .lane_o    (lane_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; enable is only consulted from IDLE and at the end of a dwell.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? REQ : IDLE;
      REQ:     state_d = mem_gnt ? FETCH : REQ;
      FETCH:   state_d = (mem_gnt && (block_q == 2'd3)) ? SHOW : FETCH;
      SHOW:    state_d = dwell_term_s ? (enable ? REQ : IDLE) : SHOW;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; chip select follows grant in the same cycle so a lost grant never reads.
  always_comb begin
    mem_req = (state_q == REQ) || (state_q == FETCH);
    mem_cs  = !((state_q == FETCH) && mem_gnt);
    mem_a   = mem_cs ? mem_a_q : addr_s;
  end

  // Counters, shadow capture and next display values.
  always_comb begin
    capture_s     = (state_q == FETCH) && mem_gnt;
    enter_show_s  = capture_s && (block_q == 2'd3);
    dwell_term_s  = (state_q == SHOW) && (dwell_q == DWELL_LAST);

    block_d       = block_q;
    row_d         = row_q;
    scan_d        = scan_q;
    frame_d       = frame_q;
    dwell_d       = dwell_q;
    shadow_d      = shadow_q;
    mem_a_d       = mem_a_q;
    col_d         = col_q;
    frame_start_d = 1'b0;
    last_frame_d  = last_frame_q;
    shown_d       = shown_q;

    if (capture_s) begin
      shadow_d[{block_q, 3'b000} +: 8] = lane_s;
      block_d = block_q + 2'd1;
      mem_a_d = addr_s;
    end else begin
      block_d = block_q;
    end

    if (state_q == SHOW) begin
      if (dwell_term_s) begin
        dwell_d = 32'd0;
        row_d   = row_q + 4'd1;
        if (row_q == ROW_LAST) begin
          if (scan_q >= SCAN_LAST) begin
            scan_d  = 16'd0;
            frame_d = (frame_q >= FRAME_LAST) ? 4'd0 : frame_q + 4'd1;
          end else begin
            scan_d  = scan_q + 16'd1;
          end
        end else begin
          scan_d = scan_q;
        end
      end else begin
        dwell_d = dwell_q + 32'd1;
      end
    end else begin
      dwell_d = 32'd0;
    end

    if (enter_show_s) begin
      col_d = shadow_d;
      if ((row_q == 4'd0) && (!shown_q || (last_frame_q != frame_q))) begin
        frame_start_d = 1'b1;
        shown_d       = 1'b1;
        last_frame_d  = frame_q;
      end else begin
        frame_start_d = 1'b0;
      end
    end else if (state_d == IDLE) begin
      col_d = 32'hFFFF_FFFF;
    end else begin
      col_d = col_q;
    end

`ifdef LED_SCAN_BRIGHTNESS_EN
    lit_s = (dwell_d[3:0] <= brightness);
`else
    lit_s = 1'b1;
`endif

    if ((state_d == SHOW) && lit_s) begin
      row_n_d = ~(16'd1 << row_d);
    end else begin
      row_n_d = 16'hFFFF;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_q       <= 2'd0;
      row_q         <= 4'd0;
      scan_q        <= 16'd0;
      frame_q       <= 4'd0;
      dwell_q       <= 32'd0;
      shadow_q      <= 32'hFFFF_FFFF;
      col_q         <= 32'hFFFF_FFFF;
      row_n_q       <= 16'hFFFF;
      mem_a_q       <= BASE_ADDR;
      frame_start_q <= 1'b0;
      last_frame_q  <= 4'd0;
      shown_q       <= 1'b0;
    end else begin
      block_q       <= block_d;
      row_q         <= row_d;
      scan_q        <= scan_d;
      frame_q       <= frame_d;
      dwell_q       <= dwell_d;
      shadow_q      <= shadow_d;
      col_q         <= col_d;
      row_n_q       <= row_n_d;
      mem_a_q       <= mem_a_d;
      frame_start_q <= frame_start_d;
      last_frame_q  <= last_frame_d;
      shown_q       <= shown_d;
    end
  end

  // Display outputs come straight from registers.
  always_comb begin
    row_n       = row_n_q;
    col_n       = col_q;
    frame_idx   = frame_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed self-checking bench for led_matrix_scanner with a small dmem model.
module tb_led_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic        mem_cs;
  logic [31:0] mem_rd;
  logic [15:0] row_n;
  logic [31:0] col_n;
  logic [3:0]  frame_idx;
  logic        frame_start;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness;
`endif

  logic [31:0] ram [0:63];
  int          checks = 0;
  int          failures = 0;
  int          fs_total = 0;
  logic [31:0] first_addr;

  always #5 clk = ~clk;

  assign mem_rd = ram[mem_a[7:2]];

  led_matrix_scanner #(
    .BASE_ADDR    (32'h1000_0000),
    .DWELL_CYCLES (16),
    .FRAME_REPEAT (2),
    .NUM_FRAMES   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_a       (mem_a),
    .mem_cs      (mem_cs),
    .mem_rd      (mem_rd),
    .row_n       (row_n),
    .col_n       (col_n),
    .frame_idx   (frame_idx),
    .frame_start (frame_start)
`ifdef LED_SCAN_BRIGHTNESS_EN
    ,
    .brightness  (brightness)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int f, input int r, input int m);
    return 32'h1000_0000 + 32'((f * 16 + m * 4 + (r % 4)) * 4);
  endfunction

  function automatic logic [31:0] col_of(input int f, input int r);
    logic [31:0] c;
    logic [31:0] w;
    c = 32'd0;
    for (int m = 0; m < 4; m++) begin
      w = ram[f * 16 + m * 4 + (r % 4)];
      c[8 * m +: 8] = w[8 * (r / 4) +: 8];
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the first SHOW sample; returns at the first sample with the row dark.
  task automatic dwell_check(input int r, input logic [31:0] exp_col, input logic exp_fs,
                             input int exp_on);
    int on;
    check_eq($sformatf("row_n_r%0d", r), {16'd0, row_n}, {16'd0, ~(16'd1 << r)});
    check_eq($sformatf("col_n_r%0d", r), col_n, exp_col);
    check_eq($sformatf("frame_start_r%0d", r), {31'd0, frame_start}, {31'd0, exp_fs});
    check_eq("show_req", {31'd0, mem_req}, 32'd0);
    on = 0;
    while (row_n != 16'hFFFF && on < 100) begin
      on++;
      fs_total += int'(frame_start);
      step();
    end
    check_eq($sformatf("dwell_on_r%0d", r), on, exp_on);
  endtask

  // Fetch with grant held: checks each block address, then the displayed row.
  task automatic do_row(input int f, input int r, input logic [31:0] exp_col,
                        input logic exp_fs, input int exp_on);
    int m;
    int budget;
    m = 0;
    budget = 0;
    while (m < 4 && budget < 60) begin
      if (mem_cs == 1'b0) begin
        check_eq($sformatf("addr_f%0d_r%0d_m%0d", f, r, m), mem_a, addr_of(f, r, m));
        if (m == 0) first_addr = mem_a;
        m++;
      end
      if (m < 4) begin
        step();
        budget++;
      end
    end
    if (m < 4) check_eq("fetch_timeout", budget, 0);
    step();
    dwell_check(r, exp_col, exp_fs, exp_on);
  endtask

  initial begin
    logic [5:0] pat;
    int m;
    int budget;
    for (int i = 0; i < 64; i++) begin
      ram[i] = {8'(8'hC0 + i), 8'(8'h80 + i), 8'(8'h40 + i), 8'(i)};
    end
    ram[5]  = ~32'h423C_7E42;
    reset   = 1'b1;
    enable  = 1'b0;
    mem_gnt = 1'b1;
`ifdef LED_SCAN_BRIGHTNESS_EN
    brightness = 4'd15;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_row_n", {16'd0, row_n}, 32'h0000_FFFF);
    check_eq("rst_col_n", col_n, 32'hFFFF_FFFF);
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_cs", {31'd0, mem_cs}, 32'd1);
    check_eq("rst_addr", mem_a, 32'h1000_0000);
    check_eq("rst_frame", {28'd0, frame_idx}, 32'd0);
    check_eq("rst_fs", {31'd0, frame_start}, 32'd0);

    reset  = 1'b0;
    enable = 1'b1;
    step();
    check_eq("req_req", {31'd0, mem_req}, 32'd1);
    check_eq("req_cs", {31'd0, mem_cs}, 32'd1);
    check_eq("req_row_n", {16'd0, row_n}, 32'h0000_FFFF);
    do_row(0, 0, 32'h0C08_0400, 1'b1, 16);
    check_eq("first_addr_f0", first_addr, 32'h1000_0000);

    // Row 1 with grant toggling 1,0,0,1,1,1 across the fetch.
    step();
    pat = 6'b111001;
    m = 0;
    for (int i = 0; i < 6; i++) begin
      mem_gnt = pat[i];
      #1;
      check_eq($sformatf("gnt_cs_%0d", i), {31'd0, mem_cs}, {31'd0, ~pat[i]});
      if (pat[i]) begin
        check_eq($sformatf("gnt_addr_%0d", i), mem_a, addr_of(0, 1, m));
        m++;
      end else begin
        check_eq($sformatf("gnt_hold_%0d", i), mem_a, addr_of(0, 1, m - 1));
      end
      step();
    end
    mem_gnt = 1'b1;
    dwell_check(1, 32'h0D09_BD01, 1'b0, 16);

    for (int r = 2; r < 16; r++) begin
      do_row(0, r, (r == 5) ? 32'h4D49_8141 : col_of(0, r), 1'b0, 16);
    end
    for (int r = 0; r < 16; r++) do_row(0, r, col_of(0, r), 1'b0, 16);
    check_eq("frame_after_32", {28'd0, frame_idx}, 32'd1);

    fs_total = 0;
    do_row(1, 0, 32'h1C18_1410, 1'b1, 16);
    check_eq("first_addr_f1", first_addr, 32'h1000_0040);
    for (int r = 1; r < 16; r++) do_row(1, r, col_of(1, r), 1'b0, 16);
    for (int r = 0; r < 16; r++) do_row(1, r, col_of(1, r), 1'b0, 16);
    check_eq("fs_pulses_f1", fs_total, 1);
    check_eq("frame_after_64", {28'd0, frame_idx}, 32'd0);

    for (int r = 0; r < 16; r++) do_row(0, r, col_of(0, r), (r == 0), 16);
    for (int r = 0; r < 16; r++) do_row(0, r, col_of(0, r), 1'b0, 16);
    check_eq("frame_before_rst", {28'd0, frame_idx}, 32'd1);

    // Reset while block 2 of frame 1 row 0 is on the bus.
    m = 0;
    budget = 0;
    while (m < 3 && budget < 60) begin
      if (mem_cs == 1'b0) m++;
      if (m < 3) begin
        step();
        budget++;
      end
    end
    check_eq("midfetch_addr", mem_a, 32'h1000_0060);
    reset = 1'b1;
    step();
    check_eq("mrst_row_n", {16'd0, row_n}, 32'h0000_FFFF);
    check_eq("mrst_cs", {31'd0, mem_cs}, 32'd1);
    check_eq("mrst_req", {31'd0, mem_req}, 32'd0);
    check_eq("mrst_frame", {28'd0, frame_idx}, 32'd0);
    reset = 1'b0;
    do_row(0, 0, 32'h0C08_0400, 1'b1, 16);
    check_eq("refetch_addr", first_addr, 32'h1000_0000);

    // Dropping enable during REQ still completes the row, then idles.
    enable = 1'b0;
    do_row(0, 1, 32'h0D09_BD01, 1'b0, 16);
    repeat (4) step();
    check_eq("idle_req", {31'd0, mem_req}, 32'd0);
    check_eq("idle_col_n", col_n, 32'hFFFF_FFFF);
    enable = 1'b1;
    do_row(0, 2, col_of(0, 2), 1'b0, 16);

`ifdef LED_SCAN_BRIGHTNESS_EN
    brightness = 4'd3;
    do_row(0, 3, col_of(0, 3), 1'b0, 4);
    budget = 0;
    while (mem_req == 1'b0 && budget < 60) begin
      step();
      budget++;
    end
    brightness = 4'd15;
    do_row(0, 4, col_of(0, 4), 1'b0, 16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
